// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants and types for the TMDS channel decoder
package tmds_pkg;

    localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

    // Indexed by the 4-bit TERC4 data value.
    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational video, control and TERC4 decode of one aligned symbol
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       ctrl_valid,
    output logic [3:0] terc4,
    output logic       terc4_valid
);

    logic [7:0] d;

    always_comb begin
        d       = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end

        ctrl       = 2'b00;
        ctrl_valid = 1'b0;
        case (sym)
            CTL_TOKEN_00: begin ctrl = 2'b00; ctrl_valid = 1'b1; end
            CTL_TOKEN_01: begin ctrl = 2'b01; ctrl_valid = 1'b1; end
            CTL_TOKEN_10: begin ctrl = 2'b10; ctrl_valid = 1'b1; end
            CTL_TOKEN_11: begin ctrl = 2'b11; ctrl_valid = 1'b1; end
            default:      begin ctrl = 2'b00; ctrl_valid = 1'b0; end
        endcase

        terc4       = 4'd0;
        terc4_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (sym == TERC4_TABLE[i]) begin
                terc4       = 4'(i);
                terc4_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel receiver: bit-slip alignment, lock FSM, registered decode
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTL_RUN       = 8,
    parameter int SEARCH_CYCLES = 2048,
    parameter int LOSS_CYCLES   = 4096
) (
    input  logic       clk_pixel,
    input  logic       resetn,
    input  logic [9:0] word_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       ctrl_valid,
    output logic [3:0] terc4,
    output logic       terc4_valid,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int RUN_W  = $clog2(CTL_RUN) + 1;
    localparam int SRCH_W = $clog2(SEARCH_CYCLES) + 1;
    localparam int LOSS_W = $clog2(LOSS_CYCLES) + 1;
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(CTL_RUN);
    localparam logic [SRCH_W-1:0] SRCH_MAX = SRCH_W'(SEARCH_CYCLES);
    localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_CYCLES);

    state_e             state_q, state_d;
    logic [3:0]         offset_q, offset_d, offset_inc;
    logic [9:0]         prev_word_q;
    logic [19:0]        window;
    logic [9:0]         sym;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [SRCH_W-1:0]  search_cnt_q, search_cnt_d;
    logic [LOSS_W-1:0]  loss_cnt_q, loss_cnt_d;
    logic [7:0]         data_q, data_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               ctrl_valid_q, ctrl_valid_d;
    logic [3:0]         terc4_q, terc4_d;
    logic               terc4_valid_q, terc4_valid_d;

    assign window = {word_in, prev_word_q};
    assign sym    = window[offset_q +: 10];

    tmds_symbol_decode u_decode (
        .sym         (sym),
        .data        (data_d),
        .ctrl        (ctrl_d),
        .ctrl_valid  (ctrl_valid_d),
        .terc4       (terc4_d),
        .terc4_valid (terc4_valid_d)
    );

    // The FSM acts on the symbol being registered this edge, so locked/offset
    // move together with the decode outputs of the deciding symbol.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        run_cnt_d    = run_cnt_q;
        search_cnt_d = search_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        offset_inc   = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

        unique case (state_q)
            SEARCH: begin
                if (!ctrl_valid_d) begin
                    run_cnt_d = '0;
                end else if (run_cnt_q != '0 && ctrl_d == ctrl_q) begin
                    run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_W'(1);
                end else begin
                    run_cnt_d = RUN_W'(1);
                end
                search_cnt_d = (search_cnt_q == SRCH_MAX) ? search_cnt_q : search_cnt_q + SRCH_W'(1);
                loss_cnt_d   = '0;

                if (run_cnt_d == RUN_MAX) begin
                    state_d      = LOCKED;
                    run_cnt_d    = '0;
                    search_cnt_d = '0;
                end else if (search_cnt_d == SRCH_MAX) begin
                    offset_d     = offset_inc;
                    run_cnt_d    = '0;
                    search_cnt_d = '0;
                end
            end
            LOCKED: begin
                loss_cnt_d = ctrl_valid_d ? '0
                           : (loss_cnt_q == LOSS_MAX) ? loss_cnt_q : loss_cnt_q + LOSS_W'(1);
                if (loss_cnt_d == LOSS_MAX) begin
                    state_d      = SEARCH;
                    offset_d     = offset_inc;
                    run_cnt_d    = '0;
                    search_cnt_d = '0;
                    loss_cnt_d   = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            state_q       <= SEARCH;
            offset_q      <= 4'd0;
            prev_word_q   <= 10'd0;
            run_cnt_q     <= '0;
            search_cnt_q  <= '0;
            loss_cnt_q    <= '0;
            data_q        <= 8'd0;
            ctrl_q        <= 2'd0;
            ctrl_valid_q  <= 1'b0;
            terc4_q       <= 4'd0;
            terc4_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            prev_word_q   <= word_in;
            run_cnt_q     <= run_cnt_d;
            search_cnt_q  <= search_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            data_q        <= data_d;
            ctrl_q        <= ctrl_d;
            ctrl_valid_q  <= ctrl_valid_d;
            terc4_q       <= terc4_d;
            terc4_valid_q <= terc4_valid_d;
        end
    end

    assign data        = data_q;
    assign ctrl        = ctrl_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign terc4       = terc4_q;
    assign terc4_valid = terc4_valid_q;
    assign locked      = (state_q == LOCKED);
    assign offset      = offset_q;

endmodule
